apb_alu_master: RTL and testbench

APB_ALU_MASTER -- requirements
Module: apb_alu_master

---
 rtl/apb_alu_master.sv | 163 ++++++++++++++++
 tb/tb_apb_alu_master.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_alu_master.sv
// APB requester that sends one packed ALU command word as a write, then reads
// the result back from the same address and returns it as a one-cycle response.
//
// state    | meaning
// IDLE     | ready for a command, bus idle
// W_SETUP  | write setup phase, packed command on pwdata
// W_ACCESS | write access phase, waiting for pready
// R_SETUP  | read setup phase
// R_ACCESS | read access phase, waiting for pready
// RESP     | one-cycle response strobe
module apb_alu_master #(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ALU_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [7:0]  cmd_op1,
  input  logic [7:0]  cmd_op2,
  input  logic [3:0]  cmd_const,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [7:0]  err_cnt,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  typedef enum logic [2:0] {
    IDLE,
    W_SETUP,
    W_ACCESS,
    R_SETUP,
    R_ACCESS,
    RESP
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] wait_cnt;
  logic [3:0] op_q;
  logic [3:0] const_q;
  logic [7:0] op1_q;
  logic [7:0] op2_q;

  // The latched fields are the only copy of the command, so pwdata is stable
  // for the whole transfer regardless of what the local side does meanwhile.
  assign pwdata = {op_q, 2'b00, const_q, op2_q, op1_q, 6'b00_0000};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      wait_cnt  <= 8'd0;
      op_q      <= 4'd0;
      const_q   <= 4'd0;
      op1_q     <= 8'd0;
      op2_q     <= 8'd0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'd0;
      rsp_err   <= 1'b0;
      err_cnt   <= 8'd0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q      <= cmd_op;
            const_q   <= cmd_const;
            op1_q     <= cmd_op1;
            op2_q     <= cmd_op2;
            cmd_ready <= 1'b0;
            psel      <= 1'b1;
            penable   <= 1'b0;
            pwrite    <= 1'b1;
            paddr     <= ALU_ADDR;
            state     <= W_SETUP;
          end
        end

        W_SETUP: begin
          penable  <= 1'b1;
          wait_cnt <= 8'd0;
          state    <= W_ACCESS;
        end

        W_ACCESS: begin
          if (pready && !pslverr) begin
            penable <= 1'b0;
            pwrite  <= 1'b0;
            state   <= R_SETUP;
          end else if (pready || wait_cnt == WAIT_LAST) begin
            // write rejected or timed out: skip the read phase
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_data  <= 32'd0;
            rsp_err   <= 1'b1;
            err_cnt   <= (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        R_SETUP: begin
          penable  <= 1'b1;
          wait_cnt <= 8'd0;
          state    <= R_ACCESS;
        end

        R_ACCESS: begin
          if (pready) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_data  <= prdata;
            rsp_err   <= pslverr;
            if (pslverr)
              err_cnt <= (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
            state     <= RESP;
          end else if (wait_cnt == WAIT_LAST) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_data  <= 32'd0;
            rsp_err   <= 1'b1;
            err_cnt   <= (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        RESP: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end

        default: begin
          psel      <= 1'b0;
          penable   <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_alu_master.sv
// Self-checking bench for apb_alu_master: a programmable APB completer plus a
// transaction-level model predicting response, latency and bus-phase lengths.
module tb_apb_alu_master;

  localparam int          TO   = 16;
  localparam logic [31:0] ADDR = 32'hA000_0040;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = 4'd0;
  logic [7:0]  cmd_op1 = 8'd0;
  logic [7:0]  cmd_op2 = 8'd0;
  logic [3:0]  cmd_const = 4'd0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [7:0]  err_cnt;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [31:0] prdata = 32'd0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;

  int errors = 0;
  int checks = 0;
  int model_err = 0;

  // completer behaviour for the current command
  int          cfg_ww = 0, cfg_rw = 0;
  bit          cfg_we = 0, cfg_re = 0;
  logic [31:0] cfg_rd = 32'd0;
  int          acc = 0;

  apb_alu_master #(.TIMEOUT(TO), .ALU_ADDR(ADDR)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_op1(cmd_op1), .cmd_op2(cmd_op2), .cmd_const(cmd_const),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .err_cnt(err_cnt),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Garbage on the response inputs outside ACCESS must be ignored.
  always @(negedge clk) begin
    if (psel && penable) begin
      if (pwrite) begin
        pready  = (acc >= cfg_ww);
        pslverr = pready && cfg_we;
        prdata  = $urandom;
      end else begin
        pready  = (acc >= cfg_rw);
        pslverr = pready && cfg_re;
        prdata  = pready ? cfg_rd : $urandom;
      end
      acc++;
    end else begin
      acc     = 0;
      pready  = 1'($urandom);
      pslverr = 1'($urandom);
      prdata  = $urandom;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] k, input int ww, input bit we, input int rw,
                         input bit re, input logic [31:0] rd, input bit hold);
    logic [31:0] exp_pw, exp_data;
    bit          exp_err, exp_read, got;
    int          wacc, racc, exp_lat, lat, n_w, n_r, n_setup, bad, n;
    exp_pw = (32'(op) << 28) + (32'(k) << 22) + (32'(b) << 14) + (32'(a) << 6);
    wacc = (ww >= TO) ? TO : ww + 1;
    exp_read = (ww < TO) && !we;
    racc = 0;
    if (!exp_read) begin
      exp_err  = 1'b1;
      exp_data = 32'd0;
    end else begin
      racc     = (rw >= TO) ? TO : rw + 1;
      exp_err  = (rw >= TO) ? 1'b1 : re;
      exp_data = (rw >= TO) ? 32'd0 : rd;
    end
    exp_lat = 1 + wacc + (exp_read ? 1 + racc : 0) + 1;
    if (exp_err && model_err < 255) model_err++;

    cfg_ww = ww; cfg_we = we; cfg_rw = rw; cfg_re = re; cfg_rd = rd;
    @(negedge clk);
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_op = op; cmd_op1 = a; cmd_op2 = b; cmd_const = k;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_op = 4'($urandom); cmd_op1 = 8'($urandom); cmd_op2 = 8'($urandom);
    cmd_const = 4'($urandom);
    if (!hold) cmd_valid = 1'b0;

    got = 0; lat = 0; n_w = 0; n_r = 0; n_setup = 0; bad = 0;
    for (int c = 1; c <= 60 && !got; c++) begin
      @(negedge clk);
      if (psel) begin
        if (pwrite) n_w++; else n_r++;
        if (!penable) n_setup++;
        if (paddr !== ADDR || pwdata !== exp_pw) bad++;
      end
      if (rsp_valid) begin
        got = 1;
        lat = c;
      end
    end
    check("rsp_latency", 32'(lat), 32'(exp_lat));
    check("rsp_data", rsp_data, exp_data);
    check("rsp_err", 32'(rsp_err), 32'(exp_err));
    check("err_cnt", 32'(err_cnt), 32'(model_err));
    check("resp_psel", 32'(psel), 32'd0);
    check("resp_cmd_ready", 32'(cmd_ready), 32'd0);
    check("write_cycles", 32'(n_w), 32'(1 + wacc));
    check("read_cycles", 32'(n_r), exp_read ? 32'(1 + racc) : 32'd0);
    check("setup_cycles", 32'(n_setup), exp_read ? 32'd2 : 32'd1);
    check("addr_wdata_stable", 32'(bad), 32'd0);
    @(negedge clk);
    check("rsp_one_cycle", 32'(rsp_valid), 32'd0);
    check("back_to_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b0;
  endtask

  initial begin
    int ww, rw, n;
    bit we, re, seen;
    repeat (3) @(negedge clk);
    check("reset_psel", 32'({psel, penable, pwrite}), 32'd0);
    check("reset_pwdata", pwdata, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("release_cmd_ready", 32'(cmd_ready), 32'd1);
    check("release_err_cnt", 32'(err_cnt), 32'd0);
    check("release_rsp", 32'({rsp_valid, rsp_err}), 32'd0);

    // zero-wait, then packed word of the reference command
    run_cmd(4'd1, 8'h12, 8'h34, 4'd0, 0, 0, 0, 0, 32'h0000_0046, 0);
    run_cmd(4'hF, 8'hFF, 8'hFF, 4'hF, 0, 0, 0, 0, 32'hDEAD_BEEF, 0);
    // wait states
    run_cmd(4'd3, 8'h5A, 8'hA5, 4'd9, 3, 0, 2, 0, 32'h1234_5678, 0);
    // write slave error
    run_cmd(4'd2, 8'h01, 8'h02, 4'd3, 0, 1, 0, 0, 32'h0BAD_0BAD, 0);
    // read slave error still returns prdata
    run_cmd(4'd4, 8'h10, 8'h20, 4'd1, 1, 0, 1, 1, 32'hCAFE_0001, 0);
    // write timeout, then a normal command
    run_cmd(4'd5, 8'h33, 8'h44, 4'd2, 99, 0, 0, 0, 32'h0, 0);
    run_cmd(4'd6, 8'h77, 8'h88, 4'd7, 0, 0, 0, 0, 32'h0000_00AB, 0);
    // one short of timeout on write, exact timeout on read
    run_cmd(4'd7, 8'h01, 8'h01, 4'd1, TO - 1, 0, 0, 0, 32'h0000_1111, 0);
    run_cmd(4'd8, 8'h02, 8'h02, 4'd2, 0, 0, TO, 0, 32'h0000_2222, 0);
    // back-pressure: cmd_valid held high while busy
    run_cmd(4'd9, 8'hC3, 8'h3C, 4'd5, 1, 0, 1, 0, 32'h5555_AAAA, 1);

    for (int i = 0; i < 40; i++) begin
      ww = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO, TO + 4)) : int'($urandom_range(0, 4));
      rw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO, TO + 4)) : int'($urandom_range(0, 4));
      we = ($urandom_range(0, 5) == 0);
      re = ($urandom_range(0, 5) == 0);
      run_cmd(4'($urandom), 8'($urandom), 8'($urandom), 4'($urandom), ww, we, rw, re,
              $urandom, 1'($urandom));
    end

    // drive err_cnt into saturation
    for (int i = 0; i < 260; i++)
      run_cmd(4'($urandom), 8'($urandom), 8'($urandom), 4'($urandom), 0, 1, 0, 0, 32'h0, 0);
    check("err_cnt_saturated", 32'(err_cnt), 32'hFF);

    // reset in the middle of a read access
    cfg_ww = 0; cfg_we = 0; cfg_rw = 99; cfg_re = 0; cfg_rd = 32'h0;
    @(negedge clk);
    cmd_op = 4'hA; cmd_op1 = 8'h11; cmd_op2 = 8'h22; cmd_const = 4'h3;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    n = 0;
    while (!(psel && penable && !pwrite) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("reached_r_access", 32'({psel, penable, pwrite}), 32'b110);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_bus_ctrl", 32'({psel, penable, pwrite}), 32'd0);
    check("rst_paddr", paddr, 32'd0);
    check("rst_pwdata", pwdata, 32'd0);
    check("rst_rsp", 32'({rsp_valid, rsp_err}), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    model_err = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid || psel) seen = 1;
    end
    check("no_rsp_after_reset", 32'(seen), 32'd0);
    check("post_reset_ready", 32'(cmd_ready), 32'd1);
    run_cmd(4'd1, 8'h12, 8'h34, 4'd0, 0, 0, 0, 0, 32'h0000_0046, 0);
    run_cmd(4'd2, 8'h21, 8'h43, 4'd6, 2, 0, 3, 0, 32'h8765_4321, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
